control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Moore-style control unit for the multi-cycle register-bus CPU.
- Sits upstream of the register select/encode logic and drives it: issues Gra/Grb/Grc with Rin/Rout/BAout, plus PC, MAR, MDR, IR, Y and Z strobes and the ALU opcode.
- Sequences fetch, then a per-class execute phase, for ALU reg-reg, ALU immediate, ld, ldi, st, nop and halt.
- Handshakes with memory through mem_ready.

Parameters:
- OPW, 5, width of opcode field ir[31:27]
- ALUW, 5, width of alu_op output

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ir  in  32  instruction register contents
- mem_ready  in  1  memory read/write complete, sampled in memory states
- Gra, Grb, Grc  out  1 each  register field selects
- Rin, Rout, BAout  out  1 each  register write / read / base-address read
- PCout, PCin, IncPC  out  1 each  program counter controls
- MARin, MDRin, MDRout  out  1 each  memory address/data register controls
- Read, Write  out  1 each  memory strobes
- IRin, Yin, Zin, Zlowout, Cout  out  1 each  datapath strobes (Cout = sign-extended ir[18:0] onto bus)
- alu_op  out  ALUW  ALU function, valid in any state asserting Zin
- run  out  1  high while executing, low in RST/HALT
- illegal  out  1  one-cycle pulse on unrecognised opcode

Behaviour:
- Reset: rst_n=0 at a clock edge puts state in RST, from any state including mid-memory-wait. In RST every output is 0. The first edge with rst_n=1 moves to T0.
- Outputs are a pure function of the current state and ir[31:27]. No output depends combinationally on mem_ready.
- alu_op is 0 whenever Zin=0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 with all T1 outputs asserted while mem_ready=0; advance when mem_ready=1. PCin is pulsed only on the entry cycle of T1, never repeated while waiting.
  - T2: MDRout, IRin.
- Decode at T3 uses ir[31:27] latched by IRin.
- Opcodes (package constants): ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, nop 11001, halt 11010.
- Reg-reg (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op=opcode, Zin.
  - T5: Zlowout, Gra, Rin, then T0.
- Immediate (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op = add/and/or code respectively.
  - T5: Zlowout, Gra, Rin.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_op=add, Zin.
  - T5: Zlowout, Gra, Rin.
- ld:
  - T3 and T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait on mem_ready.
  - T7: MDRout, Gra, Rin.
- st:
  - T3 to T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; wait on mem_ready, then T0.
- nop: T3 goes directly to T0.
- halt: T3 goes to HALT. In HALT all outputs are 0 and run=0; the state stays there until reset.
- Unrecognised opcode: illegal=1 during T3, then T0 (treated as nop).
- Cycle counts with mem_ready tied high:
  - reg-reg and immediate: 6 cycles
  - ld and st: 8 cycles
  - nop: 4 cycles
- Exactly one bus driver per state: at most one of PCout, Zlowout, MDRout, Rout, BAout or Cout is high. The bench asserts this every cycle.
- Exactly one of Gra/Grb/Grc is high whenever Rin, Rout or BAout is high.

Decomposition:
- cpu_pkg: opcode constants, ALU op codes, state enum (RST, T0 to T7, HALT), IR field bit positions.
- Single module; a separate state decode sub-module is not warranted.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> all outputs 0 and run=0. On release: T0 signals next cycle, then T1 asserts Read and PCin.
- Reg-reg: mem_ready=1, ir=0x18918000 (add R1,R2,R3) -> the T3 to T5 pattern appears exactly as specified: Grb+Rout+Yin, then Grc+Rout+Zin with alu_op=00011, then Gra+Rin+Zlowout. The next T0 comes 6 cycles after the previous T0.
- Memory wait: ir=0x00900055 (ld R1,0x55(R2)), mem_ready held low 4 cycles in T6 -> Read and MDRin stay high for 5 cycles, then T7 asserts MDRout+Gra+Rin once.
- Store: st with mem_ready=0 for 2 cycles in T7 -> Write stays high 3 cycles, Gra+Rout+MDRin appears only in T6, and the state returns to T0.
- Halt: ir=0xD0000000 -> HALT after T3 and run=0 for 20 cycles with all strobes 0. Driving rst_n=0 then 1 restarts fetch at T0.
- Illegal opcode and mid-operation reset: opcode 11111 -> illegal high for exactly 1 cycle, then T0. rst_n=0 asserted while waiting in T1 -> RST on the next edge with Read dropping.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : cpu_pkg                                                  |
// | Opcodes, ALU codes, IR field positions, sequencer states and the   |
// | opcode classifier shared by the CPU control unit.                  |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package cpu_pkg;

   // Opcode field position inside the instruction register
   localparam int IR_OP_MSB = 31;
   localparam int IR_OP_LSB = 27;
   localparam int OP_W      = IR_OP_MSB - IR_OP_LSB + 1;

   // Opcodes
   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

   // ALU function codes reuse the reg-reg opcode values
   localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;
   localparam logic [OP_W-1:0] ALU_AND = OP_AND;
   localparam logic [OP_W-1:0] ALU_OR  = OP_OR;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      CL_REGREG  = 3'd0,
      CL_IMM     = 3'd1,
      CL_LDI     = 3'd2,
      CL_LD      = 3'd3,
      CL_ST      = 3'd4,
      CL_NOP     = 3'd5,
      CL_HALT    = 3'd6,
      CL_ILLEGAL = 3'd7
   } op_class_t;

   // Map an opcode onto the execute-phase sequence it follows
   function automatic op_class_t decode_class(input logic [OP_W-1:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CL_REGREG;
         OP_ADDI, OP_ANDI, OP_ORI:      cls = CL_IMM;
         OP_LDI:                        cls = CL_LDI;
         OP_LD:                         cls = CL_LD;
         OP_ST:                         cls = CL_ST;
         OP_NOP:                        cls = CL_NOP;
         OP_HALT:                       cls = CL_HALT;
         default:                       cls = CL_ILLEGAL;
      endcase
      return cls;
   endfunction

   // ALU function used by the immediate forms
   function automatic logic [OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
      logic [OP_W-1:0] f;
      case (op)
         OP_ANDI: f = ALU_AND;
         OP_ORI:  f = ALU_OR;
         default: f = ALU_ADD;
      endcase
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : control_sequencer                                        |
// | Moore control unit for the multi-cycle register-bus CPU: fetch     |
// | (T0-T2), decode at T3, per-class execute, memory handshake.        |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     ir,
   input  logic            mem_ready,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            BAout,
   output logic            PCout,
   output logic            PCin,
   output logic            IncPC,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            Read,
   output logic            Write,
   output logic            IRin,
   output logic            Yin,
   output logic            Zin,
   output logic            Zlowout,
   output logic            Cout,
   output logic [ALUW-1:0] alu_op,
   output logic            run,
   output logic            illegal
);

   state_t          state;
   state_t          next_state;
   logic            t1_waiting;   // set on every T1 cycle after the entry cycle
   logic [OPW-1:0]  opc;
   op_class_t       cls;
   logic            mem_class;
   logic            unused_ir_bits;

   assign opc            = ir[IR_OP_MSB -: OPW];
   assign cls            = decode_class(opc);
   assign mem_class      = (cls == CL_LD) || (cls == CL_ST);
   assign unused_ir_bits = ^ir[IR_OP_LSB-1:0];

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_RST;
         t1_waiting <= 1'b0;
      end else begin
         state      <= next_state;
         t1_waiting <= (state == ST_T1) && !mem_ready;
      end
   end

   // Next-state selection
   always_comb begin
      next_state = state;
      case (state)
         ST_RST:  next_state = ST_T0;
         ST_T0:   next_state = ST_T1;
         ST_T1:   next_state = mem_ready ? ST_T2 : ST_T1;
         ST_T2:   next_state = ST_T3;
         ST_T3: begin
            case (cls)
               CL_HALT:            next_state = ST_HALT;
               CL_NOP, CL_ILLEGAL: next_state = ST_T0;
               default:            next_state = ST_T4;
            endcase
         end
         ST_T4:   next_state = ST_T5;
         ST_T5:   next_state = mem_class ? ST_T6 : ST_T0;
         ST_T6: begin
            if (cls == CL_ST)    next_state = ST_T7;
            else if (mem_ready)  next_state = ST_T7;
            else                 next_state = ST_T6;
         end
         ST_T7: begin
            if (cls == CL_LD)    next_state = ST_T0;
            else if (mem_ready)  next_state = ST_T0;
            else                 next_state = ST_T7;
         end
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_RST;
      endcase
   end

   // Moore outputs decoded from state and opcode class
   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
      Read = 1'b0; Write = 1'b0;
      IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
      alu_op  = '0;
      illegal = 1'b0;
      run     = (state != ST_RST) && (state != ST_HALT);
      case (state)
         ST_T0: begin
            // PC increment runs through the ALU as an add
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            alu_op = ALUW'(ALU_ADD);
         end
         ST_T1: begin
            Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
            PCin    = !t1_waiting;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CL_REGREG, CL_IMM: begin Grb = 1'b1; Rout  = 1'b1; Yin = 1'b1; end
               CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               CL_ILLEGAL:        illegal = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            Zin = 1'b1;
            if (cls == CL_REGREG) begin
               Grc = 1'b1; Rout = 1'b1;
               alu_op = ALUW'(opc);
            end else if (cls == CL_IMM) begin
               Cout = 1'b1;
               alu_op = ALUW'(imm_alu_op(opc));
            end else begin
               Cout = 1'b1;
               alu_op = ALUW'(ALU_ADD);
            end
         end
         ST_T5: begin
            Zlowout = 1'b1;
            if (mem_class) MARin = 1'b1;
            else begin Gra = 1'b1; Rin = 1'b1; end
         end
         ST_T6: begin
            MDRin = 1'b1;
            if (cls == CL_ST) begin Gra = 1'b1; Rout = 1'b1; end
            else Read = 1'b1;
         end
         ST_T7: begin
            if (cls == CL_ST) Write = 1'b1;
            else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_control_sequencer                                     |
// | Directed self-checking bench for control_sequencer.                |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ir = 32'h0;
   logic        mem_ready = 1'b1;
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
   logic Read, Write, IRin, Yin, Zin, Zlowout, Cout, run, illegal;
   logic [4:0]  alu_op;
   logic [20:0] strobes;
   int          total = 0;
   int          bad = 0;
   logic        mon_en = 1'b0;

   localparam logic [20:0] GRA = 21'h100000, GRB = 21'h080000, GRC = 21'h040000;
   localparam logic [20:0] RIN = 21'h020000, ROUT = 21'h010000, BAOUT = 21'h008000;
   localparam logic [20:0] PCOUT = 21'h004000, PCIN = 21'h002000, INCPC = 21'h001000;
   localparam logic [20:0] MARIN = 21'h000800, MDRIN = 21'h000400, MDROUT = 21'h000200;
   localparam logic [20:0] READ = 21'h000100, WRITE = 21'h000080, IRIN = 21'h000040;
   localparam logic [20:0] YIN = 21'h000020, ZIN = 21'h000010, ZLOW = 21'h000008;
   localparam logic [20:0] COUT = 21'h000004, RUN = 21'h000002, ILL = 21'h000001;

   localparam logic [20:0] P_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
   localparam logic [20:0] P_T1E = ZLOW | PCIN | READ | MDRIN | RUN;
   localparam logic [20:0] P_T1W = ZLOW | READ | MDRIN | RUN;
   localparam logic [20:0] P_T2  = MDROUT | IRIN | RUN;
   localparam logic [20:0] P_RR3 = GRB | ROUT | YIN | RUN;
   localparam logic [20:0] P_RR4 = GRC | ROUT | ZIN | RUN;
   localparam logic [20:0] P_WB5 = ZLOW | GRA | RIN | RUN;
   localparam logic [20:0] P_IM4 = COUT | ZIN | RUN;
   localparam logic [20:0] P_BA3 = GRB | BAOUT | YIN | RUN;
   localparam logic [20:0] P_M5  = ZLOW | MARIN | RUN;
   localparam logic [20:0] P_LD6 = READ | MDRIN | RUN;
   localparam logic [20:0] P_LD7 = MDROUT | GRA | RIN | RUN;
   localparam logic [20:0] P_ST6 = GRA | ROUT | MDRIN | RUN;
   localparam logic [20:0] P_ST7 = WRITE | RUN;

   assign strobes = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                     MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout, run, illegal};

   control_sequencer #(.OPW(5), .ALUW(5)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ready(mem_ready),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
      .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .alu_op(alu_op), .run(run),
      .illegal(illegal)
   );

   // Clock
   always #5 clk = ~clk;

   // Per-cycle structural rules: single bus driver, one register select, alu_op idle
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if ($countones({PCout, Zlowout, MDRout, Rout, BAout, Cout}) > 1) begin
            bad++;
            $display("FAIL bus_driver got=%b want<=1 driver at %0t",
                     {PCout, Zlowout, MDRout, Rout, BAout, Cout}, $time);
         end
         total++;
         if ((Rin || Rout || BAout) && $countones({Gra, Grb, Grc}) != 1) begin
            bad++;
            $display("FAIL reg_select got=%b want one-hot at %0t", {Gra, Grb, Grc}, $time);
         end
         total++;
         if (!Zin && alu_op !== 5'b0) begin
            bad++;
            $display("FAIL alu_idle got=%b want=00000 at %0t", alu_op, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; ir = 32'h18918000;
      repeat (3) tick();
      mon_en = 1'b1;
      total++;
      if (strobes !== 21'h0) begin
         bad++; $display("FAIL reset_outputs got=%h want=%h", strobes, 21'h0);
      end
      total++;
      if (alu_op !== 5'b0) begin
         bad++; $display("FAIL reset_alu got=%b want=00000", alu_op);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (strobes !== P_T0) begin
         bad++; $display("FAIL reset_release_t0 got=%h want=%h", strobes, P_T0);
      end
   endtask

   task automatic test_regreg();
      logic [20:0] es [6];
      logic [4:0]  ea [6];
      es = '{P_T1E, P_T2, P_RR3, P_RR4, P_WB5, P_T0};
      ea = '{5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
      ir = 32'h18918000; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL regreg_step%0d got=%h want=%h", i, strobes, es[i]);
         end
         if (i != 5) begin
            total++;
            if (alu_op !== ea[i]) begin
               bad++; $display("FAIL regreg_alu%0d got=%b want=%b", i, alu_op, ea[i]);
            end
         end
      end
   endtask

   task automatic test_imm();
      logic [20:0] es [6];
      logic [4:0]  ea [6];
      es = '{P_T1E, P_T2, P_RR3, P_IM4, P_WB5, P_T0};
      ea = '{5'd0, 5'd0, 5'd0, 5'b01001, 5'd0, 5'd0};
      ir = 32'h6091000F; // andi R1,R2,0xF
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL andi_step%0d got=%h want=%h", i, strobes, es[i]);
         end
         if (i != 5) begin
            total++;
            if (alu_op !== ea[i]) begin
               bad++; $display("FAIL andi_alu%0d got=%b want=%b", i, alu_op, ea[i]);
            end
         end
      end
   endtask

   task automatic test_nop();
      logic [20:0] es [4];
      es = '{P_T1E, P_T2, RUN, P_T0};
      ir = 32'hC8000000;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL nop_step%0d got=%h want=%h", i, strobes, es[i]);
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [20:0] es [6];
      es = '{P_T1E, P_T2, P_BA3, P_IM4, P_M5, P_LD6};
      ir = 32'h00900055; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL ld_step%0d got=%h want=%h", i, strobes, es[i]);
         end
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (strobes !== P_LD6) begin
            bad++; $display("FAIL ld_wait%0d got=%h want=%h", i, strobes, P_LD6);
         end
      end
      mem_ready = 1'b1;
      tick();
      total++;
      if (strobes !== P_LD7) begin
         bad++; $display("FAIL ld_t7 got=%h want=%h", strobes, P_LD7);
      end
      tick();
      total++;
      if (strobes !== P_T0) begin
         bad++; $display("FAIL ld_return got=%h want=%h", strobes, P_T0);
      end
   endtask

   task automatic test_store();
      logic [20:0] es [7];
      es = '{P_T1E, P_T2, P_BA3, P_IM4, P_M5, P_ST6, P_ST7};
      ir = 32'h10900055; mem_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL st_step%0d got=%h want=%h", i, strobes, es[i]);
         end
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (strobes !== P_ST7) begin
            bad++; $display("FAIL st_wait%0d got=%h want=%h", i, strobes, P_ST7);
         end
      end
      mem_ready = 1'b1;
      tick();
      total++;
      if (strobes !== P_T0) begin
         bad++; $display("FAIL st_return got=%h want=%h", strobes, P_T0);
      end
   endtask

   task automatic test_illegal_and_reset();
      logic [20:0] es [4];
      es = '{P_T1E, P_T2, RUN | ILL, P_T0};
      ir = 32'hF8000000;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL illegal_step%0d got=%h want=%h", i, strobes, es[i]);
         end
      end
      // Stall the fetch in T1, then reset from inside the wait
      ir = 32'h18918000; mem_ready = 1'b0;
      tick();
      total++;
      if (strobes !== P_T1E) begin
         bad++; $display("FAIL t1_entry got=%h want=%h", strobes, P_T1E);
      end
      tick();
      total++;
      if (strobes !== P_T1W) begin
         bad++; $display("FAIL t1_wait_pcin got=%h want=%h", strobes, P_T1W);
      end
      rst_n = 1'b0;
      tick();
      total++;
      if (strobes !== 21'h0) begin
         bad++; $display("FAIL midwait_reset got=%h want=%h", strobes, 21'h0);
      end
      rst_n = 1'b1; mem_ready = 1'b1;
      tick();
      total++;
      if (strobes !== P_T0) begin
         bad++; $display("FAIL midwait_restart got=%h want=%h", strobes, P_T0);
      end
   endtask

   task automatic test_halt();
      logic [20:0] es [4];
      es = '{P_T1E, P_T2, RUN, 21'h0};
      ir = 32'hD0000000;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (strobes !== es[i]) begin
            bad++; $display("FAIL halt_step%0d got=%h want=%h", i, strobes, es[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         tick();
         total++;
         if (strobes !== 21'h0 || alu_op !== 5'b0) begin
            bad++; $display("FAIL halt_hold%0d got=%h/%b want=%h/00000", i, strobes, alu_op, 21'h0);
         end
      end
      mem_ready = 1'b1; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (strobes !== P_T0) begin
         bad++; $display("FAIL halt_restart got=%h want=%h", strobes, P_T0);
      end
   endtask

   // Watchdog: the directed sequence is far shorter than this
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   // Test sequence
   initial begin
      test_reset();
      test_regreg();
      test_imm();
      test_nop();
      test_mem_wait();
      test_store();
      test_illegal_and_reset();
      test_halt();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
